// File: rtl/seg7_pkg.sv
// Shared types and widths for the seven-segment scan controller.
package seg7_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-slot cycle counter: counts 0..PRESCALE-1 and flags the blank-interval end and the slot end.
module seg7_slot_timer #(
    parameter  int unsigned PRESCALE = 50000,
    parameter  int unsigned BLANK    = 16,
    localparam int unsigned CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             blank_end,
    output logic             slot_end
);

    assign blank_end = (cnt == CNT_W'(BLANK - 1));
    assign slot_end  = (cnt == CNT_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blank interval and frame-aligned word commit.
// Optional leading-zero suppression is enabled by defining SEG7_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [BCD_W*DIGITS-1:0] value,
    input  logic                    oor,
    output logic [BCD_W-1:0]        bcd,
    output logic [DIGITS-1:0]       an,
    output logic                    frame_done,
    output logic                    err
);

    localparam int unsigned VAL_W = BCD_W * DIGITS;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0]  cnt;
    logic              blank_end;
    logic              slot_end;

    state_t            state, state_n;
    logic [VAL_W-1:0]  disp, disp_n;
    logic [VAL_W-1:0]  shadow, shadow_n;
    logic              pending, pending_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              oor_acc, oor_acc_n;
    logic              err_n;
    logic              frame_done_n;
    logic [DIGITS-1:0] an_n;
    logic [BCD_W-1:0]  bcd_n;

    logic [DIGITS-1:0] digit_en;
    logic              upper_nz;
    logic              frame_end;
    logic              accept;
    logic              oor_take;

    seg7_slot_timer #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    assign load_ready = ~pending;

    // Which digits get their enable this frame.
    always_comb begin
        upper_nz = 1'b0;
        digit_en = '1;
`ifdef SEG7_ZERO_BLANK_EN
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_nz    = upper_nz | (disp[BCD_W*k +: BCD_W] != '0);
            digit_en[k] = upper_nz | (k == 0);
        end
`endif
    end

    assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));
    assign accept    = load_valid && !pending;
    assign oor_take  = oor && (cnt >= CNT_W'(BLANK)) && digit_en[idx];

    // Next-state and registered-output logic.
    always_comb begin
        state_n      = state;
        disp_n       = disp;
        shadow_n     = shadow;
        pending_n    = pending;
        idx_n        = idx;
        oor_acc_n    = oor_acc | oor_take;
        err_n        = err;
        frame_done_n = 1'b0;
        an_n         = '0;
        bcd_n        = '0;

        case (state)
            S_BLANK: if (blank_end) state_n = S_SHOW;
            S_SHOW:  if (slot_end)  state_n = S_BLANK;
            default: state_n = S_BLANK;
        endcase

        if (slot_end) begin
            idx_n = frame_end ? '0 : idx + IDX_W'(1);
        end

        if (accept) begin
            shadow_n  = value;
            pending_n = 1'b1;
        end

        // A word already pending at the boundary blocks accept, so the two never collide.
        if (frame_end) begin
            if (pending) begin
                disp_n    = shadow;
                pending_n = 1'b0;
            end
            err_n        = oor_acc | oor_take;
            oor_acc_n    = 1'b0;
            frame_done_n = 1'b1;
        end

        if ((state_n == S_SHOW) && digit_en[idx_n]) begin
            an_n[idx_n] = 1'b1;
        end
        bcd_n = disp_n[BCD_W*idx_n +: BCD_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_BLANK;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            idx        <= '0;
            oor_acc    <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            an         <= '0;
            bcd        <= '0;
        end else begin
            state      <= state_n;
            disp       <= disp_n;
            shadow     <= shadow_n;
            pending    <= pending_n;
            idx        <= idx_n;
            oor_acc    <= oor_acc_n;
            err        <= err_n;
            frame_done <= frame_done_n;
            an         <= an_n;
            bcd        <= bcd_n;
        end
    end

endmodule
